// File: rtl/time_set_if.sv
// Button inputs and time-of-day outputs of time_set_ctrl.
// master = the side that presses buttons and watches the time; slave = the clock itself.
interface time_set_if;
  logic       hour_button;
  logic       minute_button;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       second_tick;

  modport master (
    output hour_button, minute_button,
    input  hours, minutes, seconds, second_tick
  );

  modport slave (
    input  hour_button, minute_button,
    output hours, minutes, seconds, second_tick
  );
endinterface

// File: rtl/time_set_ctrl.sv
// HH:MM:SS timekeeper with synchronized, debounced hour/minute set buttons and auto-repeat.
// Optional registered debug read port is enabled by defining TIME_SET_CTRL_DEBUG_EN.
module time_set_ctrl #(
  parameter int TICK_DIV        = 25_175_000,
  parameter int DEBOUNCE_CYCLES = 250_000,
  parameter int REPEAT_DELAY    = 12_587_500,
  parameter int REPEAT_RATE     = 2_517_500
) (
  input  logic       clock,
  input  logic       reset_n,
`ifdef TIME_SET_CTRL_DEBUG_EN
  input  logic [3:0] debug_sel,
  output logic [7:0] debug_out,
`endif
  time_set_if.slave  tif
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST    = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RR_LAST    = RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_FIRE       = 2'd1,
    ST_WAIT_DELAY = 2'd2,
    ST_WAIT_RATE  = 2'd3
  } state_t;

  // Bit 1 is the hour button, bit 0 the minute button.
  logic [1:0] btn_raw;
  logic [1:0] db_lvl;

  assign btn_raw = {tif.hour_button, tif.minute_button};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic          sync1_q, sync1_d;
      logic          sync2_q, sync2_d;
      logic          db_q, db_d;
      logic [DW-1:0] cnt_q, cnt_d;

      // The level flips only after DEBOUNCE_CYCLES consecutive differing samples.
      always_comb begin
        sync1_d = btn_raw[gi];
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        if (sync2_q != db_q) begin
          if (cnt_q == DB_LAST) begin
            db_d = sync2_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clock) begin
        if (!reset_n) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          db_q    <= 1'b0;
          cnt_q   <= '0;
        end else begin
          sync1_q <= sync1_d;
          sync2_q <= sync2_d;
          db_q    <= db_d;
          cnt_q   <= cnt_d;
        end
      end

      assign db_lvl[gi] = db_q;
    end
  endgenerate

  state_t        state_q, state_d;
  logic          owner_q, owner_d;      // 1 = hour owns the FSM, 0 = minute
  logic          repeat_q, repeat_d;    // first delay already served
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          own_db;
  logic          fire;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    repeat_d  = repeat_q;
    rpt_cnt_d = rpt_cnt_q;
    fire      = 1'b0;
    own_db    = owner_q ? db_lvl[1] : db_lvl[0];
    case (state_q)
      ST_IDLE: begin
        rpt_cnt_d = '0;
        repeat_d  = 1'b0;
        if (db_lvl[1]) begin
          owner_d = 1'b1;
          state_d = ST_FIRE;
        end else if (db_lvl[0]) begin
          owner_d = 1'b0;
          state_d = ST_FIRE;
        end
      end
      ST_FIRE: begin
        fire      = 1'b1;
        rpt_cnt_d = '0;
        if (!own_db) begin
          state_d = ST_IDLE;
        end else if (repeat_q) begin
          state_d = ST_WAIT_RATE;
        end else begin
          state_d = ST_WAIT_DELAY;
        end
      end
      ST_WAIT_DELAY: begin
        if (!own_db) begin
          state_d = ST_IDLE;
        end else if (rpt_cnt_q == RD_LAST) begin
          state_d  = ST_FIRE;
          repeat_d = 1'b1;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
      end
      ST_WAIT_RATE: begin
        if (!own_db) begin
          state_d = ST_IDLE;
        end else if (rpt_cnt_q == RR_LAST) begin
          state_d = ST_FIRE;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    hours_q, hours_d;
  logic [5:0]    minutes_q, minutes_d;
  logic [5:0]    seconds_q, seconds_d;
  logic          pend_q, pend_d;
  logic          tick;
  logic          inc_hour, inc_min;

  assign tick     = (presc_q == PRESC_LAST);
  assign inc_hour = fire & owner_q;
  assign inc_min  = fire & ~owner_q;

  // One time update per cycle: minute set, then hour set, then tick (live or pending).
  always_comb begin
    presc_d   = tick ? '0 : presc_q + 1'b1;
    hours_d   = hours_q;
    minutes_d = minutes_q;
    seconds_d = seconds_q;
    pend_d    = pend_q;
    if (inc_min) begin
      minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
      seconds_d = 6'd0;
      presc_d   = '0;
      pend_d    = 1'b0;
    end else if (inc_hour) begin
      hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
      pend_d  = pend_q | tick;
    end else if (tick | pend_q) begin
      pend_d = tick & pend_q;
      if (seconds_q == 6'd59) begin
        seconds_d = 6'd0;
        if (minutes_q == 6'd59) begin
          minutes_d = 6'd0;
          hours_d   = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
        end else begin
          minutes_d = minutes_q + 6'd1;
        end
      end else begin
        seconds_d = seconds_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      repeat_q  <= 1'b0;
      rpt_cnt_q <= '0;
      presc_q   <= '0;
      hours_q   <= 5'd0;
      minutes_q <= 6'd0;
      seconds_q <= 6'd0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      repeat_q  <= repeat_d;
      rpt_cnt_q <= rpt_cnt_d;
      presc_q   <= presc_d;
      hours_q   <= hours_d;
      minutes_q <= minutes_d;
      seconds_q <= seconds_d;
      pend_q    <= pend_d;
    end
  end

  assign tif.hours       = hours_q;
  assign tif.minutes     = minutes_q;
  assign tif.seconds     = seconds_q;
  assign tif.second_tick = tick;

`ifdef TIME_SET_CTRL_DEBUG_EN
  logic [7:0] debug_q, debug_d;

  always_comb begin
    case (debug_sel)
      4'd0:    debug_d = {state_q, owner_q, db_lvl[1], db_lvl[0], pend_q, 2'b00};
      4'd1:    debug_d = 8'(presc_q);
      4'd2:    debug_d = {2'b00, seconds_q};
      default: debug_d = 8'h00;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      debug_q <= 8'h00;
    end else begin
      debug_q <= debug_d;
    end
  end

  assign debug_out = debug_q;
`endif

endmodule
